scfifo_drain_buffer: RTL and testbench

Downstream drain stage for a single-clock FIFO operated with one-cycle read latency. Data for a read issued in cycle N is valid on `fifo_q` in cycle N+1. The block issues `fifo_rdreq` against `fifo_empty` and captures each returned word into a 3-entry output buffer. It presents the words on a registered valid/ready interface at full throughput, with no combinational path from `out_ready` to `fifo_rdreq`. It also keeps a running count of words delivered and supports a synchronous flush.

---
 rtl/scfifo_drain_buffer_if.sv | 22 ++
 rtl/scfifo_drain_buffer.sv | 86 ++++++++
 tb/tb_scfifo_drain_buffer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/scfifo_drain_buffer_if.sv
// FIFO-read and output-stream signals of the drain buffer, grouped for one-line hookup.
// Handshake: a word moves when out_valid & out_ready at a rising edge; out_data is stable while out_valid & ~out_ready.
interface scfifo_drain_buffer_if #(
  parameter int WIDTH = 1
);
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_q;
  logic             fifo_rdreq;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;

  // master: the drain buffer itself; slave: the FIFO plus downstream consumer
  modport master (
    input  fifo_empty, fifo_q, out_ready,
    output fifo_rdreq, out_valid, out_data
  );
  modport slave (
    output fifo_empty, fifo_q, out_ready,
    input  fifo_rdreq, out_valid, out_data
  );
endinterface

// File: rtl/scfifo_drain_buffer.sv
// Drain stage for a one-cycle-latency single-clock FIFO: 3-entry skid buffer with registered
// valid/data outputs, a delivered-word counter and a synchronous flush.
module scfifo_drain_buffer #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 32
) (
  input  logic                 clock,
  input  logic                 aclr_n,
  input  logic                 flush,
  scfifo_drain_buffer_if.master bus,
  output logic [1:0]           occupancy,
  output logic [CNT_W-1:0]     pop_count
);

  logic [WIDTH-1:0] store   [3];
  logic [WIDTH-1:0] store_n [3];
  logic [1:0]       rp, wp, occ;
  logic [1:0]       rp_n, wp_n, occ_n;
  logic             inflight;
  logic             valid_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] head_n;
  logic [2:0]       pending;
  logic             capture;
  logic             xfer;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Reserve a slot for every word already requested, so the buffer can never overflow.
  assign pending         = {1'b0, occ} + {2'b00, inflight};
  assign bus.fifo_rdreq  = ~bus.fifo_empty & ~flush & aclr_n & (pending <= 3'd2);
  assign capture         = inflight & ~flush;
  assign xfer            = valid_q & bus.out_ready;

  always_comb begin
    store_n = store;
    if (capture) store_n[wp] = bus.fifo_q;

    rp_n = xfer    ? ptr_inc(rp) : rp;
    wp_n = capture ? ptr_inc(wp) : wp;
    unique case ({capture, xfer})
      2'b10:   occ_n = occ + 2'd1;
      2'b01:   occ_n = occ - 2'd1;
      default: occ_n = occ;
    endcase

    if (flush) begin
      rp_n  = 2'd0;
      wp_n  = 2'd0;
      occ_n = 2'd0;
    end

    // Next head is looked up after this cycle's write, so a capture into an empty buffer appears next cycle.
    head_n = store_n[rp_n];
  end

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      for (int i = 0; i < 3; i++) store[i] <= '0;
      rp        <= 2'd0;
      wp        <= 2'd0;
      occ       <= 2'd0;
      inflight  <= 1'b0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      pop_count <= '0;
    end else begin
      store    <= store_n;
      rp       <= rp_n;
      wp       <= wp_n;
      occ      <= occ_n;
      inflight <= bus.fifo_rdreq;
      valid_q  <= (occ_n != 2'd0);
      data_q   <= head_n;
      // A transfer in the flush cycle still counts; the counter wraps freely.
      if (xfer) pop_count <= pop_count + 1'b1;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign occupancy     = occ;

endmodule

// File: tb/tb_scfifo_drain_buffer.sv
// Directed bench for scfifo_drain_buffer: behavioural FIFO model, scoreboard queue of expected
// words, and a narrow-counter twin instance for the pop_count wrap.
module tb_scfifo_drain_buffer;

  localparam int W = 8;

  logic clock = 1'b0;
  logic aclr_n;
  logic flush;
  logic gap_empty;
  logic [1:0]  occupancy, occupancy4;
  logic [31:0] pop_count;
  logic [3:0]  pop_count4;

  scfifo_drain_buffer_if #(.WIDTH(W)) bus  ();
  scfifo_drain_buffer_if #(.WIDTH(W)) bus4 ();

  scfifo_drain_buffer #(.WIDTH(W), .CNT_W(32)) dut (
    .clock(clock), .aclr_n(aclr_n), .flush(flush), .bus(bus.master),
    .occupancy(occupancy), .pop_count(pop_count)
  );

  // Twin with a 4-bit counter sees identical stimulus.
  scfifo_drain_buffer #(.WIDTH(W), .CNT_W(4)) dut4 (
    .clock(clock), .aclr_n(aclr_n), .flush(flush), .bus(bus4.master),
    .occupancy(occupancy4), .pop_count(pop_count4)
  );

  always #5 clock = ~clock;

  // FIFO model
  logic [W-1:0] mem [0:63];
  int           wr_idx = 0;
  int           rd_idx = 0;
  logic [W-1:0] fifo_q_r = '0;
  logic         rd_seen = 1'b0;
  int           cyc = 0;

  assign bus.fifo_empty  = (rd_idx == wr_idx) | gap_empty;
  assign bus.fifo_q      = fifo_q_r;
  assign bus4.fifo_empty = bus.fifo_empty;
  assign bus4.fifo_q     = bus.fifo_q;
  assign bus4.out_ready  = bus.out_ready;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (rd_seen) begin
      fifo_q_r <= mem[rd_idx];
      rd_idx   <= rd_idx + 1;
    end
  end

  // Scoreboard
  logic [W-1:0] exp_q[$];
  int n_pass = 0;
  int n_checks = 0;
  int xfer_cnt = 0;
  int xfer_cyc [0:63];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  always @(negedge clock) begin
    logic [W-1:0] e;
    rd_seen <= bus.fifo_rdreq;
    if (bus.fifo_rdreq) chk("rdreq_while_empty", {31'd0, bus.fifo_empty}, 32'd0);
    if (bus.out_valid && bus.out_ready) begin
      xfer_cnt++;
      if (xfer_cnt < 64) xfer_cyc[xfer_cnt] = cyc;
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_data", {24'd0, bus.out_data}, {24'd0, e});
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [W-1:0] v);
    mem[wr_idx] = v;
    wr_idx++;
    exp_q.push_back(v);
  endtask

  task automatic wait_xfers(input int target, input int budget, input string tag);
    for (int k = 0; k < budget && xfer_cnt < target; k++) step();
    chk({"xfer_timeout_", tag}, xfer_cnt, target);
  endtask

  int base;

  initial begin
    aclr_n        = 1'b0;
    flush         = 1'b0;
    gap_empty     = 1'b0;
    bus.out_ready = 1'b0;

    // Reset and idle: FIFO non-empty but reset held
    push(8'h01);
    repeat (3) step();
    chk("rst_rdreq",     {31'd0, bus.fifo_rdreq}, 32'd0);
    chk("rst_valid",     {31'd0, bus.out_valid},  32'd0);
    chk("rst_data",      {24'd0, bus.out_data},   32'd0);
    chk("rst_occupancy", {30'd0, occupancy},      32'd0);
    chk("rst_pop_count", pop_count,               32'd0);

    // Release in cycle N: request same cycle, valid two cycles later
    aclr_n = 1'b1;
    #1;
    chk("lat_rdreq_n", {31'd0, bus.fifo_rdreq}, 32'd1);
    step();
    chk("lat_valid_n1", {31'd0, bus.out_valid}, 32'd0);
    step();
    chk("lat_valid_n2", {31'd0, bus.out_valid}, 32'd1);
    chk("lat_data_n2",  {24'd0, bus.out_data},  32'd1);
    chk("lat_occ_n2",   {30'd0, occupancy},     32'd1);
    bus.out_ready = 1'b1;
    step();
    chk("first_pop_count", pop_count, 32'd1);

    // Streaming: 16 alternating-pattern words, no bubbles
    for (int i = 0; i < 16; i++) push(i[0] ? 8'h50 + 8'(i) : 8'hA0 + 8'(i));
    wait_xfers(17, 60, "stream");
    chk("stream_pop_count", pop_count, 32'd17);
    chk("stream_no_bubble", xfer_cyc[17] - xfer_cyc[2], 32'd15);
    chk("wrap_pop_count4",  {28'd0, pop_count4}, 32'd1);

    // Backpressure: exactly 3 pops then stall with head held
    bus.out_ready = 1'b0;
    base = rd_idx;
    for (int i = 0; i < 6; i++) push(8'hC0 + 8'(i));
    repeat (10) step();
    chk("bp_pops",      rd_idx - base,             32'd3);
    chk("bp_occupancy", {30'd0, occupancy},        32'd3);
    chk("bp_rdreq",     {31'd0, bus.fifo_rdreq},   32'd0);
    chk("bp_head",      {24'd0, bus.out_data},     32'hC0);
    step();
    chk("bp_head_hold", {24'd0, bus.out_data},     32'hC0);
    bus.out_ready = 1'b1;
    wait_xfers(23, 40, "bp");
    chk("bp_pop_count", pop_count, 32'd23);

    // Empty flag toggling every cycle
    for (int i = 0; i < 6; i++) push(8'h30 + 8'(i));
    for (int i = 0; i < 30; i++) begin
      gap_empty = ~gap_empty;
      step();
    end
    gap_empty = 1'b0;
    wait_xfers(29, 20, "gap");
    chk("gap_pop_count", pop_count, 32'd29);
    chk("gap_sb_empty",  exp_q.size(), 32'd0);

    // Flush with occ=2, one word in flight, and a transfer in the flush cycle
    bus.out_ready = 1'b0;
    step();
    for (int i = 0; i < 5; i++) push(8'hE0 + 8'(i));
    repeat (3) step();
    chk("fl_pre_occ", {30'd0, occupancy}, 32'd2);
    flush = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    chk("fl_rdreq", {31'd0, bus.fifo_rdreq}, 32'd0);
    step();
    flush = 1'b0;
    chk("fl_valid",     {31'd0, bus.out_valid}, 32'd0);
    chk("fl_occupancy", {30'd0, occupancy},     32'd0);
    chk("fl_pop_count", pop_count,              32'd30);
    // E1 (buffered) and E2 (in flight) are discarded by the flush
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
    wait_xfers(32, 20, "flush");
    chk("end_pop_count",  pop_count,             32'd32);
    chk("end_pop_count4", {28'd0, pop_count4},   32'd0);
    chk("end_sb_empty",   exp_q.size(),          32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
